stopwatch_counter: RTL
======================

# stopwatch_counter

Parametrised multi-digit stopwatch counter: a chain of modulo-N digit counters with run/pause/clear control and a lap-hold display latch. It replaces the fixed 4-bit ripple incrementer in the stopwatch datapath and feeds the display decoder directly. The default configuration is MM:SS, counting 00:00 to 59:59 on a 1 Hz tick.

## Interface
Parameters:
- NUM_DIGITS, 4, number of cascaded digits; digit 0 is least significant.
- DIGIT_W, 4, bits per digit.
- MODULI, 16'h6A6A, packed per-digit modulus; digit i is MODULI[i*DIGIT_W +: DIGIT_W]. The default gives digits 3..0 = 6,10,6,10. Each modulus must be in 2..2^DIGIT_W. A field value of 0 encodes 2^DIGIT_W.

Ports:
- clk  in  1  system clock; one clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle count-enable pulse from the prescaler.
- start_stop  in  1  single-cycle pulse that toggles run/pause.
- clear  in  1  single-cycle pulse that zeroes the count (honoured only when not running).
- lap  in  1  single-cycle pulse that toggles lap hold.
- count  out  NUM_DIGITS*DIGIT_W  live counter value.
- disp  out  NUM_DIGITS*DIGIT_W  value shown on the display: lap_reg when lapped=1, otherwise count.
- running  out  1  high in the RUN state.
- lapped  out  1  lap hold active.
- wrap  out  1  one-cycle pulse after the full chain rolls over.

## Operation
- Reset values: state IDLE, count=0, lap_reg=0, running=0, lapped=0, wrap=0.
- States:
  - IDLE: count is zero.
  - RUN: counting.
  - PAUSE: stopped with a retained value.
- Transitions:
  - IDLE --start_stop--> RUN
  - RUN --start_stop--> PAUSE
  - PAUSE --start_stop--> RUN
  - PAUSE --clear--> IDLE
  - IDLE --clear--> IDLE, with lapped cleared.
- clear is ignored in RUN.
- When clear and start_stop arrive in the same cycle in PAUSE or IDLE, clear wins: next state is IDLE and start_stop is dropped.
- Digit increment: digit i increments when tick=1, state=RUN, and every digit j<i equals MODULI_j-1.
- A digit at MODULI_i-1 that increments goes to 0. The carry into the next digit is combinational within the same cycle (ripple, no per-digit delay).
- Full rollover: when all digits are at max and an increment occurs, all digits become 0 and wrap pulses for one cycle. The counter keeps running.
- Lap behaviour:
  - In RUN, lap with lapped=0 captures count into lap_reg and sets lapped.
  - In RUN, lap with lapped=1 clears lapped.
  - In PAUSE, lap clears lapped and never captures.
  - In IDLE, lap is ignored.
- The live count keeps advancing while lapped=1.
- Arithmetic is modulo per digit. Digit values never leave 0..MODULI_i-1.

## Timing
- All state updates happen on the rising edge of clk. count, lap_reg, state and wrap are registered.
- disp, running and lapped are direct from registers or a register mux; there is no combinational path from any input.
- Count latency: a tick sampled at edge k appears on count after edge k.
- wrap is asserted in the cycle following the rollover edge, for exactly 1 cycle.
- tick and start_stop in the same cycle:
  - In IDLE: move to RUN and do not count that tick.
  - In RUN: count that tick, then go to PAUSE.
- tick and lap in the same cycle in RUN: lap_reg captures the pre-increment count.
- Reset mid-count: asynchronous assert forces all reset values immediately. Deassertion is synchronised externally; the block needs no extra logic.
- Inputs are assumed to be single-cycle pulses. A held level acts as one pulse per cycle. The debouncer/edge detector upstream owns this.

## Structure
- Shared package or include stopwatch_pkg:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2
  - default MODULI constant
  - DIGIT_W default
- Sub-module digit_inc: the combinational modulo-M single-digit incrementer, the parametrised successor of the half-adder cell.
  - Inputs: d, cin, modulus.
  - Outputs: q, cout.
- The top level generates NUM_DIGITS instances of digit_inc and owns the registers, FSM and lap latch.

## Test plan
- Reset, then start_stop, then 10 ticks. Required: count=16'h0010, disp=count, running=1.
- From count=16'h5959 in RUN, 1 tick. Required: count=16'h0000, wrap=1 for exactly one cycle, still RUN.
- In RUN at 16'h0012, lap. Then 5 ticks. Required: disp=16'h0012, count=16'h0017, lapped=1. A second lap then gives disp=16'h0017.
- In RUN, pulse clear. Required: count unchanged. Then start_stop (PAUSE), then clear. Required: count=0, state IDLE, lapped=0.
- Simultaneous tick+start_stop from IDLE. Required: RUN with count=0. Simultaneous tick+start_stop in RUN at 16'h0003. Required: PAUSE with count=16'h0004.
- Assert rst_n low mid-count at 16'h0421, asynchronously between edges. Required: count=0, disp=0, running=0, lapped=0 immediately. Also run with NUM_DIGITS=2, MODULI=8'h0A (digit 1 modulus 16): digits roll at 9 and at 15.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM encodings and default digit configuration for the stopwatch counter
package stopwatch_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;
    localparam int DIGIT_W_DEF = 4;
    localparam logic [15:0] MODULI_DEF = 16'h6A6A;
endpackage

// File: rtl/digit_inc.sv
// digit_inc: combinational modulo-M single-digit incrementer
//   d       current digit value
//   cin     increment request (carry in)
//   modulus digit modulus; 0 encodes 2^W
//   q       next digit value
//   cout    carry out, set when the digit rolls from modulus-1 to 0
module digit_inc
    import stopwatch_pkg::*;
#(
    parameter int W = DIGIT_W_DEF
) (
    input  logic [W-1:0] d,
    input  logic         cin,
    input  logic [W-1:0] modulus,
    output logic [W-1:0] q,
    output logic         cout
);
    logic at_max;
    // modulus 0 minus 1 wraps to all ones, giving the 2^W case for free
    assign at_max = d == modulus - W'(1);
    assign cout   = cin && at_max;
    assign q      = cin ? (at_max ? '0 : d + W'(1)) : d;
endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: cascaded modulo-N digit counter with run/pause/clear control and lap-hold latch
//   clk, rst_n  clock and asynchronous active-low reset
//   tick        count-enable pulse
//   start_stop  toggles run/pause
//   clear       zeroes the count when not running
//   lap         toggles lap hold
//   count       live counter value
//   disp        lap_reg while lapped, otherwise count
//   running     high in RUN
//   lapped      lap hold active
//   wrap        one-cycle pulse after full rollover
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int                            NUM_DIGITS = 4,
    parameter int                            DIGIT_W    = DIGIT_W_DEF,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] MODULI     = MODULI_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic                          start_stop,
    input  logic                          clear,
    input  logic                          lap,
    output logic [NUM_DIGITS*DIGIT_W-1:0] count,
    output logic [NUM_DIGITS*DIGIT_W-1:0] disp,
    output logic                          running,
    output logic                          lapped,
    output logic                          wrap
);
    localparam int W = NUM_DIGITS * DIGIT_W;

    state_e          state_q, state_d;
    logic [W-1:0]    count_q, count_d, lap_q, lap_d, inc;
    logic            lapped_q, lapped_d, wrap_q, wrap_d;
    logic [NUM_DIGITS:0] carry;

    assign carry[0] = tick && state_q == ST_RUN;

    // ripple carry: each digit sees the combinational carry of all lower digits
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        digit_inc #(.W(DIGIT_W)) u_digit (
            .d      (count_q[i*DIGIT_W +: DIGIT_W]),
            .cin    (carry[i]),
            .modulus(MODULI[i*DIGIT_W +: DIGIT_W]),
            .q      (inc[i*DIGIT_W +: DIGIT_W]),
            .cout   (carry[i+1])
        );
    end

    always_comb begin
        state_d  = state_q;
        count_d  = inc;
        lap_d    = lap_q;
        lapped_d = lapped_q;
        wrap_d   = carry[NUM_DIGITS];
        case (state_q)
            ST_IDLE: begin
                if (clear) lapped_d = 1'b0;
                else if (start_stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_stop) state_d = ST_PAUSE;
                if (lap) lapped_d = !lapped_q;
                // capture uses the pre-increment value
                if (lap && !lapped_q) lap_d = count_q;
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_d  = ST_IDLE;
                    count_d  = '0;
                    lapped_d = 1'b0;
                end else begin
                    if (start_stop) state_d = ST_RUN;
                    if (lap) lapped_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            lap_q    <= '0;
            lapped_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            lap_q    <= lap_d;
            lapped_q <= lapped_d;
            wrap_q   <= wrap_d;
        end
    end

    assign count   = count_q;
    assign disp    = lapped_q ? lap_q : count_q;
    assign running = state_q == ST_RUN;
    assign lapped  = lapped_q;
    assign wrap    = wrap_q;
endmodule
